soc_cluster_evt_tx: RTL



---
 rtl/soc_cluster_evt_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/soc_cluster_evt_tx.sv
// SoC-side cluster event producer: round-robin source arbiter, pending-event FIFO
// and one-hot token-ring handshake towards the cluster event unit.
module soc_cluster_evt_tx #(
    parameter int unsigned NB_SRC       = 8,
    parameter int unsigned EVNT_WIDTH   = 8,
    parameter int unsigned BUFFER_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_SRC-1:0]              evt_valid_i,
    input  logic [NB_SRC*EVNT_WIDTH-1:0]   evt_id_i,
    output logic [NB_SRC-1:0]              evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]        cluster_events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]        cluster_events_rp_i,
    output logic [EVNT_WIDTH-1:0]          cluster_events_da_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned SRC_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic [BUFFER_WIDTH-1:0] wt_q;
    logic [EVNT_WIDTH-1:0]   da_q;
    logic [BUFFER_WIDTH-1:0] rp_meta_q, rp_sync_q;
    logic [BUFFER_WIDTH-1:0] wt_rotl, wt_rotr;
    logic                    err_q, err_set;

    logic [EVNT_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    fifo_full, fifo_empty;
    logic [EVNT_WIDTH-1:0]   fifo_head;

    logic [SRC_W-1:0]        rr_ptr_q;
    logic                    grant_vld;
    logic [SRC_W-1:0]        grant_idx;
    logic [SRC_W-1:0]        grant_next;
    logic [EVNT_WIDTH-1:0]   push_id;
    logic                    push, launch;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // Round-robin search: first valid source at or after rr_ptr_q, wrapping.
    always_comb begin
        int unsigned idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_next = '0;
        push_id    = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NB_SRC; i++) begin
            idx = (32'(rr_ptr_q) + i) % NB_SRC;
            if (!grant_vld && evt_valid_i[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = SRC_W'(idx);
                grant_next = SRC_W'((idx + 1) % NB_SRC);
                push_id    = evt_id_i[idx*EVNT_WIDTH +: EVNT_WIDTH];
            end
        end
    end

    // A full FIFO blocks all sources even if the head launches this cycle.
    always_comb begin
        evt_ready_o = '0;
        if (grant_vld && !fifo_full) begin
            evt_ready_o[grant_idx] = 1'b1;
        end
    end

    assign push = grant_vld && !fifo_full;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (push) begin
            rr_ptr_q <= grant_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, launch})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rp_meta_q <= BUFFER_WIDTH'(1);
            rp_sync_q <= BUFFER_WIDTH'(1);
        end else begin
            rp_meta_q <= cluster_events_rp_i;
            rp_sync_q <= rp_meta_q;
        end
    end

    assign wt_rotl = {wt_q[BUFFER_WIDTH-2:0], wt_q[BUFFER_WIDTH-1]};
    assign wt_rotr = {wt_q[0], wt_q[BUFFER_WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    launch  = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rp_sync_q == wt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wt_q    <= BUFFER_WIDTH'(1);
            da_q    <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                wt_q <= wt_rotl;
                da_q <= fifo_head;
            end
        end
    end

    // In WAIT_ACK the cluster may still lag one slot behind the token.
    always_comb begin
        err_set = 1'b0;
        if (state_q == IDLE) begin
            err_set = (rp_sync_q != wt_q);
        end else begin
            err_set = (rp_sync_q != wt_q) && (rp_sync_q != wt_rotr);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign cluster_events_wt_o = wt_q;
    assign cluster_events_da_o = da_q;
    assign busy_o              = !fifo_empty || (state_q == WAIT_ACK);
    assign err_o               = err_q;

endmodule
